// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two writeback sources (req0 = ALU, req1 = load/syscall) onto a
// single registered register-file write port. It also keeps a per-register
// pending-write scoreboard and a saturating count of contended cycles.
//
// Handshake: a requester is accepted in a cycle iff its valid and ready are
// both 1 at the rising edge. Ready is a combinational function of the two
// valids and the priority pointer only; reg and data are sampled on the accept
// edge alone. A requester may drop valid after the accept without affecting
// the accepted write.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/reg/data, ready  ALU writeback request and its accept
//   req1_valid/reg/data, ready  load/syscall writeback request and its accept
//   reg_write/write_reg/data    registered write port, one cycle after accept
//   claim_valid, claim_reg      issue marks a destination register pending
//   query_reg_1/2, busy_1/2     pending-write lookup for two source registers
//   conflict_count              saturating count of cycles with both valid
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [4:0]       req0_reg,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_reg,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic             reg_write,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    input  logic             claim_valid,
    input  logic [4:0]       claim_reg,
    input  logic [4:0]       query_reg_1,
    input  logic [4:0]       query_reg_2,
    output logic             busy_1,
    output logic             busy_2,
    output logic [CNT_W-1:0] conflict_count
);

    // Index of the requester accepted most recently. Resets to 1 so that
    // req0 wins the first contended cycle.
    logic        last_grant;
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    logic        acc0;
    logic        acc1;
    logic        acc_any;
    logic [4:0]  acc_reg;
    logic [31:0] acc_data;
    logic        contended;

    // Under contention the requester that does not hold last_grant wins,
    // which alternates grants while both keep requesting.
    always_comb begin
        req0_ready = req0_valid & (~req1_valid | last_grant);
        req1_ready = req1_valid & (~req0_valid | ~last_grant);
    end

    always_comb begin
        acc0      = req0_valid & req0_ready;
        acc1      = req1_valid & req1_ready;
        acc_any   = acc0 | acc1;
        acc_reg   = acc1 ? req1_reg  : req0_reg;
        acc_data  = acc1 ? req1_data : req0_data;
        contended = req0_valid & req1_valid;
    end

    // Clear for the retiring write is applied first and the claim second,
    // so a new producer claiming the same register keeps it pending.
    always_comb begin
        busy_nxt = busy;
        if (acc_any) begin
            busy_nxt[acc_reg] = 1'b0;
        end
        if (claim_valid) begin
            busy_nxt[claim_reg] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Lookups read registered state only: a claim made this cycle is not
    // visible until the next cycle.
    always_comb begin
        busy_1 = busy[query_reg_1];
        busy_2 = busy[query_reg_2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= 1'b1;
            reg_write      <= 1'b0;
            write_reg      <= 5'd0;
            write_data     <= 32'd0;
            busy           <= 32'd0;
            conflict_count <= '0;
        end else begin
            if (acc_any) begin
                last_grant <= acc1;
            end
            // Writes to register 0 complete the handshake but never reach
            // the register file; the port keeps its last address/data.
            reg_write <= acc_any && (acc_reg != 5'd0);
            if (acc_any && (acc_reg != 5'd0)) begin
                write_reg  <= acc_reg;
                write_data <= acc_data;
            end
            busy <= busy_nxt;
            if (contended && (conflict_count != {CNT_W{1'b1}})) begin
                conflict_count <= conflict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        claim_valid;
    logic [4:0]  claim_reg, query_reg_1, query_reg_2;

    logic        req0_ready, req1_ready, reg_write, busy_1, busy_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [15:0] conflict_count;

    logic        s_req0_ready, s_req1_ready, s_reg_write, s_busy_1, s_busy_2;
    logic [4:0]  s_write_reg;
    logic [31:0] s_write_data;
    logic [3:0]  s_conflict_count;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .claim_valid(claim_valid), .claim_reg(claim_reg),
        .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
        .busy_1(busy_1), .busy_2(busy_2), .conflict_count(conflict_count)
    );

    regfile_write_arbiter #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(s_req1_ready),
        .reg_write(s_reg_write), .write_reg(s_write_reg), .write_data(s_write_data),
        .claim_valid(claim_valid), .claim_reg(claim_reg),
        .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
        .busy_1(s_busy_1), .busy_2(s_busy_2), .conflict_count(s_conflict_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_last = 1'b1;       // requester index that won most recently
    bit          m_busy[32];
    int unsigned m_cnt = 0;
    int unsigned m_cnt_sat = 0;
    logic [4:0]  m_hold_reg = 5'd0;
    logic [31:0] m_hold_data = 32'd0;
    logic [36:0] exp_q[$];            // write expected on the port this cycle: {reg, data}
    int          m_win;
    logic [4:0]  m_r;
    logic [31:0] m_d;

    // Which requester wins the current cycle (-1 if none), from the rules:
    // a lone requester wins; under contention the one that did not win last.
    function automatic int winner();
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 1'b1;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_cnt = 0;
            m_cnt_sat = 0;
            m_hold_reg = 5'd0;
            m_hold_data = 32'd0;
            exp_q.delete();
        end else begin
            exp_q.delete();
            m_win = winner();
            if (m_win >= 0) begin
                m_r = (m_win == 0) ? req0_reg : req1_reg;
                m_d = (m_win == 0) ? req0_data : req1_data;
                m_last = (m_win == 1);
                m_busy[m_r] = 1'b0;
                if (m_r != 5'd0) begin
                    exp_q.push_back({m_r, m_d});
                    m_hold_reg = m_r;
                    m_hold_data = m_d;
                end
            end
            if (claim_valid && claim_reg != 5'd0) m_busy[claim_reg] = 1'b1;
            if (req0_valid && req1_valid) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 15) m_cnt_sat++;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        check("req0_ready", req0_ready, winner() == 0);
        check("req1_ready", req1_ready, winner() == 1);
        check("reg_write", reg_write, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("write_reg", write_reg, exp_q[0][36:32]);
            check("write_data", write_data, exp_q[0][31:0]);
        end else begin
            check("write_reg_hold", write_reg, m_hold_reg);
            check("write_data_hold", write_data, m_hold_data);
        end
        check("busy_1", busy_1, m_busy[query_reg_1]);
        check("busy_2", busy_2, m_busy[query_reg_2]);
        check("conflict_count", conflict_count, m_cnt);
        check("sat_conflict_count", s_conflict_count, m_cnt_sat);
        check("sat_reg_write", s_reg_write, exp_q.size() > 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        claim_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        idle();
        req0_reg = 5'd0; req1_reg = 5'd0; req0_data = 32'd0; req1_data = 32'd0;
        claim_reg = 5'd0; query_reg_1 = 5'd0; query_reg_2 = 5'd0;
        #1 rst_n = 1'b0;

        // Reset state; readys follow the valids with req0 favoured.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 1);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_write_data", write_data, 0);
        check("rst_count", conflict_count, 0);
        tick();
        idle();
        rst_n = 1'b1;

        // Single request.
        req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        check("single_ready", req0_ready, 1);
        tick();
        idle();
        req0_data = 32'h12345678;
        @(negedge clk);
        check("single_reg_write", reg_write, 1);
        check("single_write_reg", write_reg, 5);
        check("single_write_data", write_data, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("single_pulse_end", reg_write, 0);
        check("single_reg_hold", write_reg, 5);

        // Contention straight after reset: grants 0,1,0,1.
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_reg = 5'(i + 1);  req0_data = $urandom;
            req1_valid = 1'b1; req1_reg = 5'(i + 10); req1_data = $urandom;
            @(negedge clk);
            check("cont_ready0", req0_ready, (i % 2) == 0);
            check("cont_ready1", req1_ready, (i % 2) == 1);
            if (i > 0) check("cont_pulse", reg_write, 1);
            tick();
        end
        idle();
        @(negedge clk);
        check("cont_last_pulse", reg_write, 1);
        check("cont_write_reg", write_reg, 13);
        check("cont_count", conflict_count, 4);
        check("cont_sat_count", s_conflict_count, 4);

        // Scoreboard: claim, retire, and claim racing a retire.
        tick();
        query_reg_1 = 5'd7;
        claim_valid = 1'b1; claim_reg = 5'd7;
        tick();
        idle();
        @(negedge clk);
        check("sb_claimed", busy_1, 1);
        tick();
        req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'hA5A5_0007;
        @(negedge clk);
        check("sb_accept_ready", req1_ready, 1);
        check("sb_no_bypass", busy_1, 1);
        tick();
        idle();
        @(negedge clk);
        check("sb_cleared", busy_1, 0);
        tick();
        claim_valid = 1'b1; claim_reg = 5'd7;
        tick();
        req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h0000_0777;
        @(negedge clk);
        check("sb_race_ready", req1_ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("sb_set_wins", busy_1, 1);

        // Register zero.
        tick();
        req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'h0000_0123;
        @(negedge clk);
        check("r0_ready", req0_ready, 1);
        tick();
        idle();
        @(negedge clk);
        check("r0_no_write", reg_write, 0);
        tick();
        claim_valid = 1'b1; claim_reg = 5'd0; query_reg_2 = 5'd0;
        tick();
        idle();
        @(negedge clk);
        check("r0_not_busy", busy_2, 0);

        // Saturation of the 4-bit counter.
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_reg = 5'd2; req1_reg = 5'd4;
        repeat (20) tick();
        @(negedge clk);
        check("sat_15", s_conflict_count, 15);
        repeat (3) tick();
        @(negedge clk);
        check("sat_hold", s_conflict_count, 15);
        tick();
        idle();

        // Reset in the middle of a pending write.
        tick();
        query_reg_1 = 5'd9;
        req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'hCAFE_0003;
        claim_valid = 1'b1; claim_reg = 5'd9;
        tick();
        check("mid_pending", reg_write, 1);
        check("mid_busy_set", busy_1, 1);
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_write", reg_write, 0);
        check("mid_rst_busy", busy_1, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_write", reg_write, 0);
        end

        // Randomized traffic with occasional resets.
        repeat (400) begin
            tick();
            rst_n       = ($urandom_range(0, 59) != 0);
            req0_valid  = ($urandom_range(0, 9) < 6);
            req1_valid  = ($urandom_range(0, 9) < 6);
            req0_reg    = 5'($urandom_range(0, 7));
            req1_reg    = 5'($urandom_range(0, 7));
            req0_data   = $urandom;
            req1_data   = $urandom;
            claim_valid = ($urandom_range(0, 9) < 3);
            claim_reg   = 5'($urandom_range(0, 7));
            query_reg_1 = 5'($urandom_range(0, 7));
            query_reg_2 = 5'($urandom_range(0, 7));
        end
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
